shiftin_rx: RTL
===============

SHIFTIN_RX -- requirements
Module: shiftin_rx

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, the frame length in bits.
REQ-002 The block SHALL have parameter TIMEOUT_CYC, default 1024, the clk_i cycles without an sclk edge before a partial frame is aborted.
REQ-003 clk_i  input  1  the single clock; all logic is on its rising edge.
REQ-004 reset_ni  input  1  reset, synchronous and active-low.
REQ-005 serial_i  input  1  serial data, asynchronous to clk_i, LSB first.
REQ-006 sclk_i  input  1  shift clock, asynchronous; data is valid at its rising edge.
REQ-007 lclk_i  input  1  latch clock, asynchronous; its rising edge ends a frame.
REQ-008 data_o  output  WIDTH  last good frame, held until the next good frame.
REQ-009 data_valid_o  output  1  one-cycle pulse when data_o updates.
REQ-010 frame_err_o  output  1  one-cycle pulse on a bad or aborted frame.
REQ-011 busy_o  output  1  high while a frame is partially received (state RECV).

Function
REQ-012 serial_i, sclk_i and lclk_i SHALL each pass through a 2-flop synchronizer, with serial_i delayed so it is sampled in the same cycle its sclk edge is detected.
REQ-013 An edge SHALL be a synchronized 0->1 transition; detection latency SHALL be 3 clk_i cycles from the input pin.
REQ-014 On each sclk edge, shreg SHALL load {serial_s, shreg[WIDTH-1:1]}, so the first bit received lands in bit 0.
REQ-015 bitcnt SHALL increment on each sclk edge and saturate at WIDTH+1; its width is $clog2(WIDTH+2).
REQ-016 States: IDLE (bitcnt=0) and RECV; IDLE->RECV on an sclk edge; RECV->IDLE on an lclk edge or a timeout.
REQ-017 On an lclk edge with bitcnt==WIDTH, data_o SHALL take shreg and data_valid_o SHALL pulse in the next cycle.
REQ-018 On an lclk edge with bitcnt!=WIDTH (including 0 and overrun), frame_err_o SHALL pulse, data_o SHALL be unchanged, and bitcnt SHALL clear.
REQ-019 If sclk and lclk edges coincide, the latch SHALL use the pre-shift shreg/bitcnt, and the coincident bit SHALL start the next frame (bitcnt=1, state RECV).
REQ-020 In RECV, an idle counter SHALL clear on each sclk edge and count otherwise.
REQ-021 When the idle counter reaches TIMEOUT_CYC-1, frame_err_o SHALL pulse, bitcnt SHALL clear, and the state SHALL return to IDLE.
REQ-022 data_valid_o and frame_err_o SHALL never be high in the same cycle.
REQ-023 The block SHALL accept back-to-back frames with no dead time between an lclk edge and the next sclk edge.

Reset
REQ-024 While reset_ni=0 at a clk_i edge, data_o=0, data_valid_o=0, frame_err_o=0, busy_o=0, state=IDLE, shreg=0, bitcnt=0, idle counter=0, and all synchronizer flops=0.
REQ-025 Reset asserted mid-frame SHALL discard the partial frame with no error pulse.
REQ-026 A line held high through reset release SHALL NOT produce an edge.

Structure
REQ-027 Package shiftio_pkg SHALL hold the WIDTH default (16), the receiver state enum and the bit-counter width function, shared with the shiftout transmitter.
REQ-028 A sub-module sync_edge (2-flop synchronizer plus rising-edge detect, outputs level and pulse) SHALL be instantiated for sclk_i and lclk_i; serial_i SHALL use the same synchronizer without the edge output.

Verification
REQ-029 Drive 0xA5C3 from the shiftout transmitter (16 bits LSB first, then lclk) -> data_o=0xA5C3, one data_valid_o pulse, frame_err_o=0.
REQ-030 Send 15 bits then lclk -> one frame_err_o pulse, data_o keeps its prior value; then a 16-bit frame 0x0001 -> data_o=0x0001.
REQ-031 Send 17 bits then lclk -> frame_err_o pulse; the next good frame 0xFFFF is accepted.
REQ-032 Send 8 bits then stall 1024 cycles -> frame_err_o pulse, busy_o=0; then a full frame 0x1234 -> data_o=0x1234.
REQ-033 Send 16 bits with the 17th sclk edge coincident with lclk -> data_valid_o pulse with the 16-bit value, and busy_o=1 with bitcnt=1.
REQ-034 Assert reset_ni=0 after 10 bits, release, then send 0xBEEF -> data_o=0xBEEF, no frame_err_o pulse anywhere.

Source files
------------

// File: rtl/shiftio_pkg.sv
// Shared definitions for the shiftin/shiftout serial pair.
// Holds the default frame width, receiver states and bit-counter sizing.
package shiftio_pkg;

  localparam int DEF_WIDTH = 16;

  typedef enum logic {
    RX_IDLE = 1'b0,
    RX_RECV = 1'b1
  } rx_state_e;

  // Counter must represent 0..width+1 so an overrun frame stays distinguishable.
  function automatic int bitcnt_width(input int width);
    return $clog2(width + 2);
  endfunction

endpackage

// File: rtl/sync_edge.sv
// 2-flop synchronizer with rising-edge detect; level after 2 cycles, pulse acted on at the 3rd.
// No backpressure: every synchronized 0->1 transition produces exactly one pulse.
module sync_edge (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic d_i,
  output logic level_o,
  output logic pulse_o
);

  logic       s1_q, s2_q, s3_q;
  logic [2:0] arm_q;

  // arm_q[2] means s3_q holds a real post-reset sample, so a line high
  // through reset release is not mistaken for a rising edge.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      s3_q  <= 1'b0;
      arm_q <= 3'b000;
    end else begin
      s1_q  <= d_i;
      s2_q  <= s1_q;
      s3_q  <= s2_q;
      arm_q <= {arm_q[1:0], 1'b1};
    end
  end

  assign level_o = s2_q;
  assign pulse_o = s2_q & ~s3_q & arm_q[2];

endmodule

// File: rtl/shiftin_rx.sv
// Serial frame receiver: shifts LSB-first bits on sclk edges, latches on lclk edges, 3-cycle pin-to-action latency.
// No backpressure: frames are accepted back-to-back; bad, overrun or stalled frames pulse frame_err_o.
module shiftin_rx
  import shiftio_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             serial_i,
  input  logic             sclk_i,
  input  logic             lclk_i,
  output logic [WIDTH-1:0] data_o,
  output logic             data_valid_o,
  output logic             frame_err_o,
  output logic             busy_o
);

  localparam int CNT_W  = bitcnt_width(WIDTH);
  localparam int IDLE_W = $clog2(TIMEOUT_CYC);

  logic serial_s, sclk_edge, lclk_edge;
  logic unused_serial_pulse, unused_sclk_level, unused_lclk_level;

  // serial level comes out of the same 2-flop depth as sclk, so it is
  // sampled in the cycle its sclk edge is seen.
  sync_edge u_sync_serial (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .d_i      (serial_i),
    .level_o  (serial_s),
    .pulse_o  (unused_serial_pulse)
  );

  sync_edge u_sync_sclk (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .d_i      (sclk_i),
    .level_o  (unused_sclk_level),
    .pulse_o  (sclk_edge)
  );

  sync_edge u_sync_lclk (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .d_i      (lclk_i),
    .level_o  (unused_lclk_level),
    .pulse_o  (lclk_edge)
  );

  rx_state_e           state_q, state_d;
  logic [WIDTH-1:0]    shreg_q, shreg_d;
  logic [CNT_W-1:0]    bitcnt_q, bitcnt_d;
  logic [IDLE_W-1:0]   idle_q, idle_d;
  logic [WIDTH-1:0]    data_q, data_d;
  logic                vld_q, vld_d;
  logic                err_q, err_d;

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    idle_d   = idle_q;
    data_d   = data_q;
    vld_d    = 1'b0;
    err_d    = 1'b0;

    // The latch decision uses pre-shift shreg/bitcnt; a coincident sclk
    // edge below then starts the next frame from bitcnt=1.
    if (lclk_edge) begin
      if (bitcnt_q == CNT_W'(WIDTH)) begin
        data_d = shreg_q;
        vld_d  = 1'b1;
      end else begin
        err_d  = 1'b1;
      end
      bitcnt_d = '0;
      idle_d   = '0;
      state_d  = RX_IDLE;
    end

    if (sclk_edge) begin
      shreg_d = {serial_s, shreg_q[WIDTH-1:1]};
      if (lclk_edge) begin
        bitcnt_d = CNT_W'(1);
      end else if (bitcnt_q != CNT_W'(WIDTH + 1)) begin
        bitcnt_d = bitcnt_q + CNT_W'(1);
      end
      idle_d  = '0;
      state_d = RX_RECV;
    end else if (!lclk_edge && state_q == RX_RECV) begin
      if (idle_q == IDLE_W'(TIMEOUT_CYC - 1)) begin
        err_d    = 1'b1;
        bitcnt_d = '0;
        idle_d   = '0;
        state_d  = RX_IDLE;
      end else begin
        idle_d = idle_q + IDLE_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q  <= RX_IDLE;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      idle_q   <= '0;
      data_q   <= '0;
      vld_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      idle_q   <= idle_d;
      data_q   <= data_d;
      vld_q    <= vld_d;
      err_q    <= err_d;
    end
  end

  assign data_o       = data_q;
  assign data_valid_o = vld_q;
  assign frame_err_o  = err_q;
  assign busy_o       = (state_q == RX_RECV);

endmodule
